// File: rtl/minsoc_uart_rx.sv
// -----------------------------------------------------------------------------
// minsoc_uart_rx
//
// UART receiver for the minsoc SoC. It decodes frames from the asynchronous
// serial line into words and stores them in a first-word-fall-through receive
// FIFO. Framing errors, parity errors and overruns are recorded in sticky
// status flags.
//
// Frame format: one start bit (low), DATA_BITS data bits sent LSB first, an
// optional parity bit, then STOP_BITS stop bits (high). Each bit is sampled
// once, at its middle, using a baud counter that is realigned on every start
// bit edge.
//
// Parameters
//   DATA_BITS    payload bits per frame (5..8)
//   BAUD_DIV     clock cycles per bit (>= 4)
//   PARITY_MODE  0 = none, 1 = odd, 2 = even
//   STOP_BITS    1 or 2
//   FIFO_AW      log2 of the FIFO depth
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rxd          serial input, idle high, asynchronous to clk
//   rx_data      FIFO head word, meaningful while rx_valid is high
//   rx_valid     FIFO non-empty
//   rx_ready     consumer pop; a word is removed when rx_valid && rx_ready
//   fifo_count   FIFO occupancy, 0 .. 2**FIFO_AW
//   frame_err    sticky: a stop bit was sampled low
//   parity_err   sticky: a parity mismatch was seen
//   overrun      sticky: a good frame was dropped because the FIFO was full
//   err_clr      single-cycle pulse that clears the three sticky flags
// -----------------------------------------------------------------------------
module minsoc_uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int BAUD_DIV    = 217,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_AW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [BW-1:0]    HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0]    FULL_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  localparam logic             ODD_MODE  = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Idle-high reset value so that reset release does not
  // look like a start bit.
  // ---------------------------------------------------------------------------
  logic rxd_m;
  logic rxd_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rxd_s see the previous rxd_m,
      // giving two real flop stages; blocking here would collapse them.
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_t               state, state_d;
  logic [BW-1:0]        bcnt, bcnt_d;
  logic [3:0]           bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 perr, perr_d;     // parity mismatch in current frame
  logic                 ferr, ferr_d;     // low stop bit seen in current frame
  logic                 sample;
  logic                 stop_bad;
  logic                 word_ok;          // good frame completed this cycle
  logic                 set_fe;
  logic                 set_pe;

  assign sample = (bcnt == '0);

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    state_d   = state;
    bcnt_d    = bcnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    perr_d    = perr;
    ferr_d    = ferr;
    word_ok   = 1'b0;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    stop_bad  = ferr | ~rxd_s;

    // The baud counter only runs while a frame is being decoded.
    if (state != IDLE && state != WAIT_IDLE) begin
      bcnt_d = sample ? FULL_LOAD : bcnt - 1'b1;
    end

    case (state)
      IDLE: begin
        if (!rxd_s) begin
          // Half a bit ahead so every later sample lands mid-bit.
          bcnt_d  = HALF_LOAD;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (sample) begin
          if (rxd_s) begin
            state_d = IDLE;            // start bit too short: glitch
          end else begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end

      DATA: begin
        if (sample) begin
          // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
          shreg_d = {rxd_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end

      PARITY: begin
        if (sample) begin
          // XOR over data and parity is 1 for an odd count of ones.
          perr_d  = (^{shreg, rxd_s}) ^ ODD_MODE;
          state_d = STOP;
        end
      end

      STOP: begin
        if (sample) begin
          ferr_d = stop_bad;
          if (bit_cnt == LAST_STOP) begin
            if (stop_bad) begin
              set_fe  = 1'b1;
              state_d = WAIT_IDLE;     // hold off until the line recovers
            end else if (perr) begin
              set_pe  = 1'b1;
              state_d = IDLE;
            end else begin
              word_ok = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end

      WAIT_IDLE: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bcnt    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_d;
      bcnt    <= bcnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      perr    <= perr_d;
      ferr    <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr;
  logic [FIFO_AW:0]     rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 set_ov;

  assign fifo_count = wr_ptr - rd_ptr;
  assign rx_valid   = (wr_ptr != rd_ptr);
  assign full       = (fifo_count == FULL_CNT);
  assign pop        = rx_valid & rx_ready;
  // A simultaneous pop frees the slot being written, so a full FIFO still
  // accepts the word in that cycle.
  assign push       = word_ok & (~full | pop);
  assign set_ov     = word_ok & full & ~pop;
  assign rx_data    = mem[rd_ptr[FIFO_AW-1:0]];

  // NOTE: the storage array has no reset; its contents are only observed
  // behind rx_valid, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status. A new event outranks a clear in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (set_fe)       frame_err  <= 1'b1;
      else if (err_clr) frame_err  <= 1'b0;
      if (set_pe)       parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (set_ov)       overrun    <= 1'b1;
      else if (err_clr) overrun    <= 1'b0;
    end
  end

endmodule

// File: doc/minsoc_uart_rx.md
# minsoc_uart_rx

Parametrised, synthesizable UART receiver for the minsoc SoC, replacing the behavioural start-bit/mid-bit sampling decoder used in simulation with a hardware block. Adds configurable data width, optional parity, one or two stop bits, a first-word-fall-through receive FIFO with valid/ready pop, and sticky framing/parity/overrun status. It sits between the board `uart_srx` pin and a bus-side register wrapper, and is also usable as a bench monitor.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..8, sent LSB first.
- `BAUD_DIV`, 217: clock cycles per bit (FREQ/UART_BAUDRATE), ≥ 4.
- `PARITY_MODE`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_AW`, 4: FIFO depth = 2^FIFO_AW entries.

- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rxd`, in, 1: serial line, idle high, asynchronous to `clk`.
- `rx_data`, out, DATA_BITS: FIFO head word; valid only when `rx_valid`=1.
- `rx_valid`, out, 1: FIFO non-empty.
- `rx_ready`, in, 1: consumer pop; a pop happens when `rx_valid && rx_ready`.
- `fifo_count`, out, FIFO_AW+1: current occupancy, 0..2^FIFO_AW.
- `frame_err`, out, 1: sticky; a stop bit was sampled low.
- `parity_err`, out, 1: sticky; a parity mismatch occurred.
- `overrun`, out, 1: sticky; a good frame arrived while the FIFO was full.
- `err_clr`, in, 1: one-cycle pulse that clears all three sticky flags.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) to produce `rxd_s`. All decoding uses `rxd_s`.
- The FSM has states IDLE, START, DATA, PARITY, STOP, and WAIT_IDLE. A baud counter `bcnt` fires a sample when it reaches 0, then reloads with BAUD_DIV-1.
- IDLE: when `rxd_s`=0, load `bcnt`=BAUD_DIV/2-1 and go to START.
- START: on sample, if `rxd_s`=1 the start is a glitch; return to IDLE with no flag set. Otherwise clear the bit counter and go to DATA.
- DATA: on each sample, shift `rxd_s` in at the MSB (LSB-first frame). After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else go to STOP.
- PARITY: on sample, compare against the expected parity. Odd mode requires an odd count of ones across data and parity bits; even mode requires an even count. Record a mismatch in a frame-local `perr` bit.
- STOP: sample STOP_BITS times. If any sampled stop bit is 0, the frame has a framing error.
- Disposition on the final stop sample:
  - Framing error: set `frame_err`, discard the word, go to WAIT_IDLE.
  - Else if `perr`: set `parity_err`, discard the word, go to IDLE.
  - Else if the FIFO is full and no pop occurs this cycle: set `overrun`, discard the word, go to IDLE.
  - Else: push the word, go to IDLE.
- WAIT_IDLE: stay until `rxd_s`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err` and no pushes.
- FIFO: register array with read/write pointers of FIFO_AW+1 bits each. `fifo_count` = wr - rd. `rx_data` = mem[rd[FIFO_AW-1:0]], combinational.
- Sticky flags: if a set and `err_clr` occur in the same cycle, the set wins.

## Timing
- Reset values: FSM=IDLE, pointers=0, `rx_valid`=0, `fifo_count`=0, `rx_data`=mem[0] (don't-care), all flags=0, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately. After release the FSM is in IDLE; if `rxd` is still low, it starts a new frame detection.
- Latency: a falling `rxd` edge reaches `rxd_s` 2 cycles later. Each sample lands at mid-bit ±1 cycle.
- A push occurs on the final stop-sample edge. `rx_valid`, `fifo_count`, and `rx_data` update on the next cycle.
- A pop takes effect on the clock edge; the next head word is visible the following cycle.
- Push and pop in the same cycle leave `fifo_count` unchanged. This holds when full, so no overrun is flagged in that case.
- `rx_ready` while `rx_valid`=0 is ignored. Pointers wrap modulo 2^(FIFO_AW+1).
- Minimum frame-to-frame spacing: the next start bit may begin immediately after the nominal end of the last stop bit.

## Test plan
- Back-to-back frames: BAUD_DIV=8, 8N1, bytes 0x55 then 0xA3, `rx_ready`=1. Required: `rx_valid` pulses twice with 0x55 then 0xA3, each 1 cycle after its stop-sample; no flags set.
- Parity error: PARITY_MODE=2, byte 0x07 sent with parity bit 0. Required: `parity_err`=1, `fifo_count` stays 0. Then pulse `err_clr`; required: `parity_err`=0.
- Glitch rejection: `rxd` low for 3 cycles at BAUD_DIV=16. Required: no push and no flags; the FSM is back in IDLE within 10 cycles.
- Break: `rxd` held low for 20 bit times, then released. Required: `frame_err`=1 exactly once, `fifo_count`=0. A following 0x41 frame is received correctly.
- Overrun: FIFO_AW=4, `rx_ready`=0, bytes 0x00..0x10 sent. Required: `fifo_count`=16, `overrun`=1, and pops return 0x00..0x0F in order. Also drive 1 frame ending while full with a simultaneous pop; required: the word is accepted and `overrun` is not newly set.
- Reset mid-frame: assert `reset` low during DATA bit 4, release, then send 0x3C. Required: all outputs at reset values during reset, and exactly one push of 0x3C afterwards.
